// File: rtl/booth_mul_pkg.sv
// Shared definitions for the Booth multiplier datapath: accumulator FSM encoding,
// default product width and the saturation bounds used by the accumulator.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_t;

  localparam int DEF_PROD_W = 64;

  // Saturation bounds are built at this fixed width and truncated to ACC_W by the user.
  localparam int ACC_W_MAX = 128;

  function automatic logic [ACC_W_MAX-1:0] acc_max(input int accW);
    return (ACC_W_MAX'(1) << (accW - 1)) - ACC_W_MAX'(1);
  endfunction

  function automatic logic [ACC_W_MAX-1:0] acc_min(input int accW);
    return ACC_W_MAX'(1) << (accW - 1);
  endfunction

endpackage

// File: rtl/booth_mac_accumulator_sat_adder.sv
// Combinational signed ACC_W adder with overflow flag.
// Build option MAC_ACC_SAT_EN clamps the sum to the signed range on overflow.
module mac_sat_adder
  import booth_mul_pkg::*;
#(
  parameter int ACC_W = 72
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  logic [ACC_W-1:0] w_raw;

  assign w_raw = i_a + i_b;
  assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

`ifdef MAC_ACC_SAT_EN
  localparam logic [ACC_W_MAX-1:0] MAX_WIDE = acc_max(ACC_W);
  localparam logic [ACC_W_MAX-1:0] MIN_WIDE = acc_min(ACC_W);
  localparam logic [ACC_W-1:0]     SAT_MAX  = MAX_WIDE[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     SAT_MIN  = MIN_WIDE[ACC_W-1:0];

  // On overflow both operands share a sign, which picks the clamp direction.
  assign o_sum = o_ovf ? (i_a[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/booth_mac_accumulator.sv
// Accumulates BLOCK_LEN signed products from the Booth multiplier and presents the
// sum with a valid/ack handshake. MAC_ACC_SAT_EN selects saturating accumulation.
module booth_mac_accumulator
  import booth_mul_pkg::*;
#(
  parameter int  PROD_W    = DEF_PROD_W,
  parameter int  GUARD     = 8,
  parameter int  BLOCK_LEN = 4,
  localparam int ACC_W     = PROD_W + GUARD
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     start,
  input  logic                     mul_ready,
  input  logic signed [PROD_W-1:0] mul_r,
  output logic                     busy,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  input  logic                     acc_ack,
  output logic                     ovf,
  output logic                     drop
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  mac_state_t              r_state;
  mac_state_t              w_stateNext;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic                    r_drop;
  logic                    r_readyQ;

  logic                    w_capture;
  logic                    w_lastCapture;
  logic [CNT_W-1:0]        w_cntNext;
  logic signed [ACC_W-1:0] w_prodExt;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_addOvf;

  assign w_capture     = mul_ready & ~r_readyQ;
  assign w_cntNext     = r_cnt + CNT_W'(1);
  assign w_lastCapture = w_capture && (w_cntNext == CNT_W'(BLOCK_LEN));
  assign w_prodExt     = {{GUARD{mul_r[PROD_W-1]}}, mul_r};

  mac_sat_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .i_a  (r_acc),
    .i_b  (w_prodExt),
    .o_sum(w_sum),
    .o_ovf(w_addOvf)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) r_state <= IDLE;
    else              r_state <= w_stateNext;
  end

  // A start in ACCUM restarts the block in place; start is ignored in HOLD.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:    if (start) w_stateNext = ACCUM;
      ACCUM:   if (!start && w_lastCapture) w_stateNext = HOLD;
      HOLD:    if (acc_ack) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    acc_valid = 1'b0;
    case (r_state)
      ACCUM:   busy = 1'b1;
      HOLD:    acc_valid = 1'b1;
      default: ;
    endcase
  end

  assign acc_out = r_acc;
  assign ovf     = r_ovf;
  assign drop    = r_drop;

  // Captures that coincide with start are discarded; captures outside ACCUM are flagged.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
      r_readyQ <= 1'b0;
    end else begin
      r_readyQ <= mul_ready;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_drop <= 1'b0;
          end else if (w_capture) begin
            r_drop <= 1'b1;
          end
        end
        ACCUM: begin
          if (start) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_drop <= 1'b0;
          end else if (w_capture) begin
            r_acc <= w_sum;
            r_cnt <= w_cntNext;
            if (w_addOvf) r_ovf <= 1'b1;
          end
        end
        HOLD: begin
          if (w_capture) r_drop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: a default-width instance checked through
// a scoreboard, plus a GUARD=1 instance on the same inputs for the overflow case.
module tb_booth_mac_accumulator;

  typedef struct {
    logic [71:0] acc;
    logic        ovf;
  } exp_t;

  logic               clk = 1'b0;
  logic               asyncRstN;
  logic               start;
  logic               mulReady;
  logic signed [63:0] mulR;
  logic               accAck;

  logic               busyA, accValidA, ovfA, dropA;
  logic signed [71:0] accOutA;
  logic               busyB, accValidB, ovfB, dropB;
  logic [64:0]        accOutB;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [71:0] expAcc;

  always #5 clk = ~clk;

  booth_mac_accumulator dutA (
    .clk        (clk),
    .async_rst_n(asyncRstN),
    .start      (start),
    .mul_ready  (mulReady),
    .mul_r      (mulR),
    .busy       (busyA),
    .acc_out    (accOutA),
    .acc_valid  (accValidA),
    .acc_ack    (accAck),
    .ovf        (ovfA),
    .drop       (dropA)
  );

  booth_mac_accumulator #(
    .PROD_W   (64),
    .GUARD    (1),
    .BLOCK_LEN(4)
  ) dutB (
    .clk        (clk),
    .async_rst_n(asyncRstN),
    .start      (start),
    .mul_ready  (mulReady),
    .mul_r      (mulR),
    .busy       (busyB),
    .acc_out    (accOutB),
    .acc_valid  (accValidB),
    .acc_ack    (accAck),
    .ovf        (ovfB),
    .drop       (dropB)
  );

  function automatic logic [71:0] sx(input logic [63:0] v);
    return {{8{v[63]}}, v};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic startPulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expAcc = '0;
  endtask

  task automatic ackPulse();
    @(negedge clk);
    accAck = 1'b1;
    @(negedge clk);
    accAck = 1'b0;
  endtask

  // One rising edge of mul_ready carrying v; the model adds it when counted.
  task automatic applyStimulus(input logic [63:0] v, input bit counted);
    @(negedge clk);
    mulR     = v;
    mulReady = 1'b1;
    @(negedge clk);
    mulReady = 1'b0;
    if (counted) expAcc = expAcc + sx(v);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   waited = 0;
    while (accValidA !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, 72'(waited), 72'd0);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s_scoreboard observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_acc"}, accOutA, e.acc);
      check({tag, "_ovf"}, 72'(ovfA), 72'(e.ovf));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed hang expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    asyncRstN = 1'b0;
    start     = 1'b0;
    mulReady  = 1'b0;
    mulR      = '0;
    accAck    = 1'b0;
    expAcc    = '0;

    // Reset state
    @(negedge clk);
    check("rst_acc", accOutA, 72'd0);
    check("rst_valid", 72'(accValidA), 72'd0);
    check("rst_busy", 72'(busyA), 72'd0);
    check("rst_ovf", 72'(ovfA), 72'd0);
    check("rst_drop", 72'(dropA), 72'd0);
    @(negedge clk);
    asyncRstN = 1'b1;

    // Basic block of four mixed-sign products
    $display("[TB] basic block");
    startPulse();
    check("t1_busy", 72'(busyA), 72'd1);
    applyStimulus(64'd6, 1'b1);
    applyStimulus(-64'sd3, 1'b1);
    applyStimulus(64'd100, 1'b1);
    applyStimulus(-64'sd1, 1'b1);
    sb.push_back('{acc: expAcc, ovf: 1'b0});
    checkOutput("t1");
    check("t1_model", expAcc, 72'd102);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_hold_acc", accOutA, 72'd102);
      check("t1_hold_valid", 72'(accValidA), 72'd1);
    end
    ackPulse();
    check("t1_ack_valid", 72'(accValidA), 72'd0);
    check("t1_ack_busy", 72'(busyA), 72'd0);
    check("t1_ack_acc", accOutA, 72'd102);

    // Level-held ready yields a single capture
    $display("[TB] held ready");
    startPulse();
    @(negedge clk);
    mulR     = 64'd7;
    mulReady = 1'b1;
    expAcc   = expAcc + sx(64'd7);
    repeat (30) @(negedge clk);
    check("t2_still_busy", 72'(busyA), 72'd1);
    check("t2_not_valid", 72'(accValidA), 72'd0);
    mulReady = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(64'd7, 1'b1);
    sb.push_back('{acc: expAcc, ovf: 1'b0});
    checkOutput("t2");
    ackPulse();

    // Large products: overflow only in the narrow-guard instance
    $display("[TB] overflow");
    startPulse();
    for (int i = 0; i < 4; i++) applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    sb.push_back('{acc: expAcc, ovf: 1'b0});
    checkOutput("t3");
    check("t3_model", expAcc, 72'h1_FFFF_FFFF_FFFF_FFFC);
    check("t3b_valid", 72'(accValidB), 72'd1);
    check("t3b_ovf", 72'(ovfB), 72'd1);
`ifdef MAC_ACC_SAT_EN
    check("t3b_acc", 72'(accOutB), 72'h0_FFFF_FFFF_FFFF_FFFF);
`else
    check("t3b_acc", 72'(accOutB), 72'h1_FFFF_FFFF_FFFF_FFFC);
`endif
    ackPulse();

    // Restart mid-block; coincident capture is discarded
    $display("[TB] restart");
    startPulse();
    applyStimulus(64'd5, 1'b1);
    applyStimulus(64'd9, 1'b1);
    @(negedge clk);
    start    = 1'b1;
    mulReady = 1'b1;
    mulR     = 64'd123;
    @(negedge clk);
    start    = 1'b0;
    mulReady = 1'b0;
    expAcc   = '0;
    check("t4_busy", 72'(busyA), 72'd1);
    for (int i = 0; i < 4; i++) applyStimulus(64'd1, 1'b1);
    sb.push_back('{acc: expAcc, ovf: 1'b0});
    checkOutput("t4");
    check("t4_drop", 72'(dropA), 72'd0);

    // Capture, start and ack together in HOLD
    $display("[TB] hold collisions");
    @(negedge clk);
    start    = 1'b1;
    mulReady = 1'b1;
    accAck   = 1'b1;
    mulR     = 64'd55;
    @(negedge clk);
    start    = 1'b0;
    mulReady = 1'b0;
    accAck   = 1'b0;
    check("t5_drop", 72'(dropA), 72'd1);
    check("t5_acc", accOutA, 72'd4);
    check("t5_busy", 72'(busyA), 72'd0);
    check("t5_valid", 72'(accValidA), 72'd0);
    @(negedge clk);
    check("t5_idle", 72'(busyA), 72'd0);

    // Asynchronous reset mid-block, then a negative block
    $display("[TB] async reset");
    startPulse();
    check("t6_drop_clr", 72'(dropA), 72'd0);
    applyStimulus(-64'sd2, 1'b1);
    applyStimulus(-64'sd2, 1'b1);
    @(negedge clk);
    #2 asyncRstN = 1'b0;
    #1;
    check("t6_rst_acc", accOutA, 72'd0);
    check("t6_rst_busy", 72'(busyA), 72'd0);
    check("t6_rst_valid", 72'(accValidA), 72'd0);
    @(negedge clk);
    asyncRstN = 1'b1;
    applyStimulus(64'd99, 1'b0);
    check("t6_idle_drop", 72'(dropA), 72'd1);
    startPulse();
    check("t6_start_drop", 72'(dropA), 72'd0);
    for (int i = 0; i < 4; i++) applyStimulus(-64'sd2, 1'b1);
    sb.push_back('{acc: expAcc, ovf: 1'b0});
    checkOutput("t6");
    check("t6_model", expAcc, 72'hFF_FFFF_FFFF_FFFF_FFF8);
    ackPulse();
    check("sb_empty", 72'(sb.size()), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
